// File: rtl/cylon_pkg.sv
// Shared mode/direction codes, switch field positions and step-period helper.
// Pure definitions; no logic, no latency, no flow control.
// Imported by cylon_scanner.
package cylon_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_WRAP_L = 2'b01,
        MODE_WRAP_R = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int SW_SPEED_LSB = 0;
    localparam int SW_SPEED_MSB = 1;
    localparam int SW_MODE_LSB  = 2;
    localparam int SW_MODE_MSB  = 3;

    // Each speed step halves the period; never let it collapse to zero.
    function automatic logic [27:0] step_period(input logic [27:0] base, input logic [1:0] speed);
        logic [27:0] p;
        p = base >> speed;
        return (p == 28'd0) ? 28'd1 : p;
    endfunction

endpackage

// File: rtl/cylon_btn_debounce.sv
// Button synchroniser + debouncer emitting a one-cycle press event on accepted 0->1.
// Latency: press high in the cycle after edge DEBOUNCE_CYCLES+2 from first raw-high sample.
// Backpressure: none; free-running, events are single-cycle pulses.
module cylon_btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic        meta;
    logic        sync;
    logic        level;
    logic [19:0] cnt;
    logic        settle;

    // The synced level has disagreed with the accepted one for long enough.
    assign settle = (sync != level) && (cnt == DEBOUNCE_CYCLES - 20'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            press <= settle & sync;
            if (sync == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/cylon_scanner.sv
// One-hot Cylon eye scanner with bounce/wrap/freeze modes, switch speed and button steering.
// Latency: led and pulse registered on the tick edge; sw visible 2 edges after sampling.
// Backpressure: none; free-running display driver.
module cylon_scanner
    import cylon_pkg::*;
#(
    parameter int          N_LEDS                 = 16,
    parameter logic [27:0] CLOCK_CYCLES_PER_PULSE = 28'd100_000_000,
    parameter logic [19:0] DEBOUNCE_CYCLES        = 20'd1_000_000
) (
    input  logic              clk,
    input  logic              btnC,
    input  logic [3:0]        sw,
    input  logic              btnL,
    input  logic              btnR,
    output logic [N_LEDS-1:0] led,
    output logic              pulse
);

    localparam int              PW      = $clog2(N_LEDS);
    localparam logic [PW-1:0]   POS_MAX = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]   POS_ONE = PW'(1);
    localparam logic [N_LEDS-1:0] LED_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

    logic [3:0]    sw_meta;
    logic [3:0]    sw_sync;
    logic          press_l;
    logic          press_r;
    logic          ev_l;
    logic          ev_r;
    logic [27:0]   period;
    logic [27:0]   tick_cnt;
    logic          tick;
    mode_t         mode;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_nxt;
    dir_t          dir;
    dir_t          dir_nxt;

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign mode   = mode_t'(sw_sync[SW_MODE_MSB:SW_MODE_LSB]);
    assign period = step_period(CLOCK_CYCLES_PER_PULSE, sw_sync[SW_SPEED_MSB:SW_SPEED_LSB]);
    // >= rather than == so a speed-up that strands the counter past the new period ticks at once.
    assign tick   = (tick_cnt >= period - 28'd1);

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? 28'd0 : tick_cnt + 28'd1;
        end
    end

    cylon_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk   (clk),
        .rst   (btnC),
        .raw   (btnL),
        .press (press_l)
    );

    cylon_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk   (clk),
        .rst   (btnC),
        .raw   (btnR),
        .press (press_r)
    );

    // Conflicting presses cancel each other.
    assign ev_l = press_l & ~press_r;
    assign ev_r = press_r & ~press_l;

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        case (mode)
            MODE_BOUNCE: begin
                if (ev_l) begin
                    dir_nxt = DIR_LEFT;
                end else if (ev_r) begin
                    dir_nxt = DIR_RIGHT;
                end
                if (tick) begin
                    if (dir_nxt == DIR_LEFT) begin
                        if (pos == POS_MAX) begin
                            dir_nxt = DIR_RIGHT;
                            pos_nxt = POS_MAX - POS_ONE;
                        end else begin
                            pos_nxt = pos + POS_ONE;
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_nxt = DIR_LEFT;
                            pos_nxt = POS_ONE;
                        end else begin
                            pos_nxt = pos - POS_ONE;
                        end
                    end
                end
            end
            MODE_WRAP_L: begin
                dir_nxt = DIR_LEFT;
                if (tick) begin
                    pos_nxt = (pos == POS_MAX) ? '0 : pos + POS_ONE;
                end
            end
            MODE_WRAP_R: begin
                dir_nxt = DIR_RIGHT;
                if (tick) begin
                    pos_nxt = (pos == '0) ? POS_MAX : pos - POS_ONE;
                end
            end
            MODE_FREEZE: begin
                if (ev_l && pos != POS_MAX) begin
                    pos_nxt = pos + POS_ONE;
                end else if (ev_r && pos != '0) begin
                    pos_nxt = pos - POS_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            pos   <= '0;
            dir   <= DIR_LEFT;
            led   <= LED_ONE;
            pulse <= 1'b0;
        end else begin
            pos   <= pos_nxt;
            dir   <= dir_nxt;
            led   <= LED_ONE << pos_nxt;
            pulse <= tick;
        end
    end

endmodule

// File: tb/tb_cylon_scanner.sv
// Randomised and directed bench for cylon_scanner against a behavioural reference model.
module tb_cylon_scanner;

    localparam int N    = 16;
    localparam int BASE = 500;
    localparam int DC   = 4;

    logic         clk;
    logic         btnC;
    logic         btnL;
    logic         btnR;
    logic [3:0]   sw;
    logic [N-1:0] led;
    logic         pulse;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference model state
    int             m_pos;
    int             m_cnt;
    bit             m_dir;
    bit             m_pulse;
    logic [3:0]     sw_d [0:2];
    logic [DC+1:0]  hl;
    logic [DC+1:0]  hr;
    bit             acc_l, acc_r, pend_l, pend_r;

    cylon_scanner #(
        .N_LEDS                 (N),
        .CLOCK_CYCLES_PER_PULSE (28'd500),
        .DEBOUNCE_CYCLES        (20'd4)
    ) dut (
        .clk   (clk),
        .btnC  (btnC),
        .sw    (sw),
        .btnL  (btnL),
        .btnR  (btnR),
        .led   (led),
        .pulse (pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos   = 0;
        m_dir   = 0;
        m_cnt   = 0;
        m_pulse = 0;
        for (int k = 0; k < 3; k++) sw_d[k] = 4'h0;
        hl      = '0;
        hr      = '0;
        acc_l   = 0;
        acc_r   = 0;
        pend_l  = 0;
        pend_r  = 0;
    endtask

    // A button level is accepted once the last DC synced samples all oppose it.
    function automatic bit settled_flip(input logic [DC+1:0] h, input bit acc);
        for (int k = 2; k <= DC + 1; k++) begin
            if (h[k] == acc) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        int period;
        int mode;
        bit ev_l, ev_r, tick, fl, fr;
        if (btnC) begin
            model_reset();
            return;
        end
        sw_d[2] = sw_d[1];
        sw_d[1] = sw_d[0];
        sw_d[0] = sw;
        hl = {hl[DC:0], btnL};
        hr = {hr[DC:0], btnR};
        mode   = int'(sw_d[2][3:2]);
        period = BASE >> sw_d[2][1:0];
        if (period < 1) period = 1;
        ev_l = pend_l && !pend_r;
        ev_r = pend_r && !pend_l;
        fl = settled_flip(hl, acc_l);
        fr = settled_flip(hr, acc_r);
        pend_l = fl && !acc_l;
        pend_r = fr && !acc_r;
        if (fl) acc_l = !acc_l;
        if (fr) acc_r = !acc_r;
        tick  = (m_cnt >= period - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        case (mode)
            0: begin
                if (ev_l) m_dir = 0;
                if (ev_r) m_dir = 1;
                if (tick) begin
                    if (m_dir == 0) begin
                        if (m_pos == N - 1) begin m_dir = 1; m_pos = N - 2; end
                        else m_pos = m_pos + 1;
                    end else begin
                        if (m_pos == 0) begin m_dir = 0; m_pos = 1; end
                        else m_pos = m_pos - 1;
                    end
                end
            end
            1: begin
                m_dir = 0;
                if (tick) m_pos = (m_pos + 1) % N;
            end
            2: begin
                m_dir = 1;
                if (tick) m_pos = (m_pos + N - 1) % N;
            end
            default: begin
                if (ev_l && m_pos < N - 1) m_pos = m_pos + 1;
                if (ev_r && m_pos > 0)     m_pos = m_pos - 1;
            end
        endcase
        m_pulse = tick;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_eq("led", 32'(led), 32'd1 << m_pos);
            check_eq("pulse", 32'(pulse), 32'(m_pulse));
        end
    endtask

    task automatic press(input bit l, input bit r, input int hold, input int gap);
        btnL = l;
        btnR = r;
        run(hold);
        btnL = 1'b0;
        btnR = 1'b0;
        run(gap);
    endtask

    // Asserts reset between clock edges and checks it takes effect without a clock.
    task automatic async_reset();
        #2 btnC = 1'b1;
        #1;
        model_reset();
        check_eq("async_led", 32'(led), 32'h1);
        check_eq("async_pulse", 32'(pulse), 32'h0);
        run(3);
        btnC = 1'b0;
    endtask

    task automatic run_until_pos(input int target, input int limit);
        for (int i = 0; i < limit && m_pos != target; i++) run(1);
        check_eq("reach_pos", 32'(led), 32'd1 << target);
    endtask

    initial begin
        logic [N-1:0] held;
        int pulses;
        int lat;
        btnC = 1'b1;
        btnL = 1'b0;
        btnR = 1'b0;
        sw   = 4'h3;
        model_reset();

        phase = "reset";
        run(20);
        btnC = 1'b0;

        phase = "bounce";
        run(62 * 32);

        phase = "wrap_l";
        sw = 4'h7;
        run(62 * 10);
        press(1'b0, 1'b1, 10, 10);
        run(62 * 8);
        press(1'b1, 1'b0, 10, 10);
        run(62 * 4);

        phase = "wrap_r";
        sw = 4'hB;
        run(62 * 10);
        press(1'b1, 1'b0, 10, 10);
        run(62 * 8);

        phase = "freeze";
        sw = 4'hF;
        run(4);
        held   = led;
        pulses = 0;
        for (int i = 0; i < 2000; i++) begin
            run(1);
            if (pulse) pulses++;
        end
        check_eq("freeze_hold", 32'(led), 32'(held));
        check_eq("freeze_pulses", 32'(pulses >= 32 && pulses <= 33), 32'h1);

        // Press latency: event after edge DC+2, position update one edge later.
        held = led;
        btnL = 1'b1;
        lat  = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            run(1);
            if (led != held) lat = i;
        end
        check_eq("press_latency", 32'(lat), 32'(DC + 3));
        check_eq("press_step", 32'(led), 32'(held) << 1);
        btnL = 1'b0;
        run(10);

        for (int i = 0; i < 17; i++) press(1'b1, 1'b0, 10, 10);
        check_eq("sat_left", 32'(led), 32'h8000);
        for (int i = 0; i < 17; i++) press(1'b0, 1'b1, 10, 10);
        check_eq("sat_right", 32'(led), 32'h0001);

        phase = "debounce";
        press(1'b1, 1'b0, 10, 10);
        held = led;
        press(1'b0, 1'b1, 3, 10);
        check_eq("glitch", 32'(led), 32'(held));
        press(1'b1, 1'b1, 10, 10);
        check_eq("both_btn", 32'(led), 32'(held));

        phase = "steer";
        sw = 4'h3;
        async_reset();
        run_until_pos(4, 62 * 6);
        press(1'b0, 1'b1, 10, 0);
        for (int i = 0; i < 80 && m_pos == 4; i++) run(1);
        check_eq("steer_step", 32'(led), 32'h0008);

        phase = "speed";
        run_until_pos(10, 62 * 40);
        sw = 4'h0;
        async_reset();
        run(300);
        sw  = 4'h3;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            run(1);
            if (pulse) lat = i;
        end
        check_eq("speed_drop_latency", 32'(lat), 32'd3);

        phase = "random";
        for (int seg = 0; seg < 40; seg++) begin
            int hold;
            sw   = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            case ($urandom_range(0, 5))
                0: run(hold);
                1: press(1'b1, 1'b0, hold, $urandom_range(1, 12));
                2: press(1'b0, 1'b1, hold, $urandom_range(1, 12));
                3: press(1'b1, 1'b1, hold, $urandom_range(1, 12));
                4: press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, DC - 1), 8);
                default: async_reset();
            endcase
            run($urandom_range(20, 200));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cylon_scanner.md
# cylon_scanner

Parametrised successor to the current Cylon LED scanner. It drives an `N_LEDS`-wide one-hot "eye" across the LED bar. Run mode is selectable: bounce, wrap-left, wrap-right or freeze. Speed is switch-selectable, and the debounced left/right buttons steer or single-step the eye. It sits directly under `cylon_top`, between the board switches/buttons and `led`.

## Interface
- `N_LEDS`, 16: LED count. Must be ≥ 2.
- `CLOCK_CYCLES_PER_PULSE`, 28'd100_000_000: base step period in `clk` cycles (speed 0).
- `DEBOUNCE_CYCLES`, 20'd1_000_000: consecutive stable synced samples required to accept a button level. Must be ≥ 1.
- `clk` input 1: system clock.
- `btnC` input 1: reset. One clock; reset is asynchronous and active-high.
- `sw` input 4: `sw[1:0]` speed, `sw[3:2]` mode. Raw, asynchronous.
- `btnL` input 1: raw left button (toward higher LED index).
- `btnR` input 1: raw right button (toward lower LED index).
- `led` output N_LEDS: one-hot eye, registered.
- `pulse` output 1: registered step tick, one cycle wide.

## Operation
- **Input synchronisation.** `sw`, `btnL` and `btnR` each pass through a 2-flop synchroniser.
  - Mode and speed take effect from the synchronised `sw`.
- **Debounce**, per button.
  - `cnt` clears whenever synced input equals the accepted level; otherwise it increments.
  - When `cnt == DEBOUNCE_CYCLES-1`, the accepted level takes the synced value.
  - A press event is a one-cycle pulse on an accepted 0→1 transition. Releases generate nothing.
- **Tick.** `period = max(1, CLOCK_CYCLES_PER_PULSE >> speed)`.
  - The tick counter runs 0..period-1.
  - The tick fires on the cycle where `count >= period-1`, and the counter returns to 0 on that cycle.
  - Therefore a speed change that leaves `count` beyond the new period causes a tick on the next cycle.
- **State.** `pos` (0..N_LEDS-1) and `dir` (0 = left/up, 1 = right/down). `led = 1 << pos` at all times.
- **Modes** (codes in `cylon_pkg`): 00 BOUNCE, 01 WRAP_L, 10 WRAP_R, 11 FREEZE.
- **BOUNCE**, on tick:
  - If `dir` is left and `pos == N_LEDS-1`: `dir` becomes right and `pos` becomes `N_LEDS-2`. Otherwise `pos+1`.
  - The right direction is symmetric at 0: `dir` becomes left and `pos` becomes 1.
  - A btnL event sets `dir` to left; a btnR event sets `dir` to right.
- **WRAP_L**, on tick: `pos = (pos == N_LEDS-1) ? 0 : pos+1`. `dir` is forced to left. Buttons are ignored.
- **WRAP_R**, on tick: `pos = (pos == 0) ? N_LEDS-1 : pos-1`. `dir` is forced to right. Buttons are ignored.
- **FREEZE**:
  - Ticks do not move the eye, but `pulse` still fires.
  - A btnL event does `pos+1`, saturating at `N_LEDS-1`.
  - A btnR event does `pos-1`, saturating at 0.
  - `dir` is unchanged.
- **Simultaneous events.**
  - btnL and btnR events in the same cycle are both ignored.
  - A button event coinciding with a tick in BOUNCE updates `dir` first; the same-cycle step uses the new `dir`.
  - A mode change is applied on the same edge as any coincident tick, using the new mode.

## Timing
- **Reset values:** `led = 1` (bit 0), `pulse = 0`, `pos = 0`, `dir = left`. Tick counter, debounce counters, accepted levels and synchronisers all reset to 0.
- **Reset mid-operation** returns to the reset state immediately, asynchronously. Stepping resumes `period` cycles after the release edge.
- **`pulse` vs. `led`:** `pulse` is high in the cycle after a tick fires. `led` changes on that same edge.
- **Press latency:** for a clean press, the press event is high in the cycle after edge `DEBOUNCE_CYCLES+2`, counted from the first edge that samples the raw input high. The effect on `pos`/`dir` is registered one edge later.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Switch latency:** a `sw` change is visible to the mode/speed logic 2 edges after sampling.

## Structure
- **`cylon_pkg`:**
  - Mode codes: `MODE_BOUNCE`, `MODE_WRAP_L`, `MODE_WRAP_R`, `MODE_FREEZE`.
  - Direction constants: `DIR_LEFT = 0`, `DIR_RIGHT = 1`.
  - Switch field indices for speed and mode.
- **Sub-module `cylon_btn_debounce`**, instantiated twice (btnL, btnR):
  - Contains the 2-flop synchroniser, debounce counter and press-event output.
  - Parameter `DEBOUNCE_CYCLES`.
- **`cylon_scanner`** holds the `sw` synchroniser, tick counter, the `pos`/`dir` state machine and the `led` decode.

## Test plan
All scenarios use `N_LEDS = 16`, `CLOCK_CYCLES_PER_PULSE = 500`, `DEBOUNCE_CYCLES = 4` and a 10 ns clock.

1. **Reset and bounce.** Assert `btnC` for 200 ns with `sw = 4'h3` (BOUNCE, period 62).
   - During reset: `led = 16'h0001`, `pulse = 0`.
   - After release: `led` steps 0001, 0002, … 8000, then 4000, … every 62 cycles.
   - `pulse` is one cycle wide and aligned with each `led` change.
2. **Wrap modes.**
   - `sw = 4'h7` (WRAP_L): `led` goes 8000 → 0001.
   - `sw = 4'hB` (WRAP_R): `led` goes 0001 → 8000.
   - `btnL`/`btnR` presses cause no direction change.
3. **Freeze.** `sw = 4'hF`.
   - `led` is constant over 2000 cycles while `pulse` keeps firing every 62 cycles.
   - Hold `btnL` for 10 cycles: `led` shifts exactly one bit left.
   - At `led = 16'h8000`, `btnL` leaves it at 8000.
   - Same saturation test with `btnR` at 0001.
4. **Debounce.**
   - A 3-cycle `btnR` glitch produces no event.
   - `btnL` and `btnR` pressed simultaneously for 10 cycles produce no `pos`/`dir` change.
5. **Steer in BOUNCE.** While moving left at `led = 16'h0010`, press `btnR`. The next tick gives `16'h0008`.
6. **Reset and speed change mid-operation.**
   - Assert `btnC` while at `16'h0400`: `led = 16'h0001` asynchronously.
   - Drop speed from 0 to 3 at tick count 300: a tick fires on the next cycle (after synchroniser latency).
